load_store_sequencer: RTL and testbench
=======================================

LOAD_STORE_SEQUENCER -- requirements
Module: load_store_sequencer

Interface
REQ-001 Parameter BEAT_BYTES, 1, bytes per data-memory beat; legal values 1, 2, 4.
REQ-002 Parameter ADDR_W, 32, address width.
REQ-003 sysclk  in  1  sole clock; all state on rising edge.
REQ-004 sysreset  in  1  asynchronous, active-low reset.
REQ-005 req_valid  in  1  core access request.
REQ-006 req_ready  out  1  request accepted when req_valid && req_ready.
REQ-007 req_we  in  1  1 = store, 0 = load.
REQ-008 req_funct3  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 req_addr  in  ADDR_W  byte address.
REQ-010 req_wdata  in  32  store data, little-endian, size-masked.
REQ-011 rsp_valid  out  1  one-cycle completion pulse.
REQ-012 rsp_rdata  out  32  sign/zero-extended load data; 0 for stores.
REQ-013 rsp_err  out  1  qualified by rsp_valid; illegal or trapped access.
REQ-014 dmem_en  out  1  beat issue strobe.
REQ-015 dmem_we  out  1  beat is a write.
REQ-016 dmem_addr  out  ADDR_W  beat byte address, BEAT_BYTES-aligned.
REQ-017 dmem_be  out  BEAT_BYTES  byte-lane enables.
REQ-018 dmem_din  out  8*BEAT_BYTES  write data.
REQ-019 dmem_dout  in  8*BEAT_BYTES  read data, valid exactly one cycle after the issuing beat.

Function
REQ-020 States IDLE, ISSUE, DRAIN, RESP; req_ready = 1 only in IDLE.
REQ-021 Accept in IDLE: latch we, funct3, addr, wdata; next state ISSUE, or RESP with rsp_err = 1 for illegal funct3 (load 011/11x, store >= 011).
REQ-022 Access size S = 1/2/4 bytes; beat count N = max(1, S/BEAT_BYTES); beat counter runs 0..N-1.
REQ-023 ISSUE beat k: dmem_en = 1, dmem_addr = aligned_base + k*BEAT_BYTES, dmem_be covers only the accessed bytes within that beat.
REQ-024 ISSUE lasts exactly N cycles; after last beat: load -> DRAIN, store -> RESP.
REQ-025 Load data of beat k is captured into its byte lanes on the edge ending the cycle after issue; DRAIN captures the final beat.
REQ-026 RESP: rsp_valid = 1 for one cycle, then IDLE; no response backpressure.
REQ-027 Latency, accept edge to rsp_valid cycle: load N+2 cycles, store N+1 cycles, error 1 cycle.
REQ-028 Outside ISSUE: dmem_en = dmem_we = 0, dmem_be = 0.
REQ-029 Extension: B/H sign-extend bit 7/15; BU/HU zero-extend; W passes through.
REQ-030 Address arithmetic wraps modulo 2^ADDR_W.

Reset
REQ-031 sysreset low: state IDLE, counter 0, all outputs 0 except req_ready = 1, taking effect immediately and independent of sysclk.
REQ-032 Reset mid-access aborts it: no rsp_valid, partial store beats are not retracted.

Configuration
REQ-033 LSU_MISALIGN_TRAP_EN defined: address not S-aligned -> RESP with rsp_err = 1 after 1 cycle, no dmem beat issued.
REQ-034 LSU_MISALIGN_TRAP_EN undefined: low address bits are cleared to S alignment, the access proceeds normally, and rsp_err is asserted only for illegal funct3.

Structure
REQ-035 Package lsu_pkg: state enum, funct3 width-code constants, legal BEAT_BYTES check.
REQ-036 Sub-module lsu_load_extend: combinational byte assembly and sign/zero extension.

Verification
REQ-037 BEAT_BYTES=1, LW addr 0x100, memory 0x11,0x22,0x33,0x44: 4 beats at 0x100..0x103, rsp_rdata 0x44332211 at cycle 6.
REQ-038 BEAT_BYTES=4, LB addr 0x203, byte 0x80: one beat, dmem_be 4'b1000, rsp_rdata 0xFFFFFF80; LBU gives 0x00000080.
REQ-039 BEAT_BYTES=2, SW addr 0x40, wdata 0xDEADBEEF: beats 0x40 din 0xBEEF and 0x42 din 0xDEAD, be 2'b11, rsp_valid at cycle 3.
REQ-040 LH addr 0x101: with macro, rsp_err = 1 and no dmem_en; without macro, access at 0x100 completes with rsp_err = 0.
REQ-041 Illegal funct3 011 on a load: rsp_err = 1 one cycle after accept, no beats issued.
REQ-042 Reset asserted during beat 2 of a 4-beat LW: dmem_en drops immediately, no rsp_valid, next request accepted normally after release.

Source files
------------

// File: rtl/load_store_sequencer_pkg.sv
// Shared types and helpers for the load/store sequencer: FSM state encoding,
// RV32I load/store width codes and the BEAT_BYTES legality check.
package lsu_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_RESP  = 2'd3
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic bit beat_bytes_legal(input int bb);
        return (bb == 1) || (bb == 2) || (bb == 4);
    endfunction

    // Stores only have signed-width codes; loads also allow the unsigned ones.
    function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
        if (we) begin
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    // log2 of the access size in bytes; only meaningful for legal codes.
    function automatic logic [1:0] size_log2(input logic [1:0] f3_low);
        return f3_low;
    endfunction

endpackage

// File: rtl/load_store_sequencer_if.sv
// Core-request, response and data-memory signals of the load/store sequencer,
// with a slave view for the sequencer and a master view for its environment.
interface load_store_sequencer_if #(
    parameter int ADDR_W     = 32,
    parameter int BEAT_BYTES = 1
);
    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // the requester holds its fields stable while req_valid is high and unaccepted.
    // rsp_valid is a one-cycle pulse with no backpressure; dmem has no ready at all.
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_we;
    logic [2:0]              req_funct3;
    logic [ADDR_W-1:0]       req_addr;
    logic [31:0]             req_wdata;

    logic                    rsp_valid;
    logic [31:0]             rsp_rdata;
    logic                    rsp_err;

    logic                    dmem_en;
    logic                    dmem_we;
    logic [ADDR_W-1:0]       dmem_addr;
    logic [BEAT_BYTES-1:0]   dmem_be;
    logic [8*BEAT_BYTES-1:0] dmem_din;
    logic [8*BEAT_BYTES-1:0] dmem_dout;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        input  dmem_en, dmem_we, dmem_addr, dmem_be, dmem_din,
        output dmem_dout
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        output dmem_en, dmem_we, dmem_addr, dmem_be, dmem_din,
        input  dmem_dout
    );

endinterface

// File: rtl/load_store_sequencer_load_extend.sv
// Combinational load-data assembly: shifts the addressed bytes down from the
// captured beat buffer and sign/zero-extends according to the width code.
module lsu_load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] data,
    input  logic [1:0]  lane_off,
    input  logic [2:0]  funct3,
    output logic [31:0] rdata
);

    logic [31:0] raw;

    always_comb begin
        raw   = data >> {lane_off, 3'b000};
        rdata = '0;
        case (funct3)
            F3_B:    rdata = {{24{raw[7]}}, raw[7:0]};
            F3_H:    rdata = {{16{raw[15]}}, raw[15:0]};
            F3_W:    rdata = raw;
            F3_BU:   rdata = {24'b0, raw[7:0]};
            F3_HU:   rdata = {16'b0, raw[15:0]};
            default: rdata = '0;
        endcase
    end

endmodule

// File: rtl/load_store_sequencer.sv
// Load/store sequencer: splits one RV32I byte/half/word access into BEAT_BYTES-wide
// data-memory beats. Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses.
module load_store_sequencer
    import lsu_pkg::*;
#(
    parameter int BEAT_BYTES = 1,
    parameter int ADDR_W     = 32
) (
    input  logic                  sysclk,
    input  logic                  sysreset,
    load_store_sequencer_if.slave bus,
    output lsu_state_e            fsm_state
);

    localparam int               LG_BB     = (BEAT_BYTES == 4) ? 2 : (BEAT_BYTES == 2) ? 1 : 0;
    localparam int               MAX_BEATS = 4 / BEAT_BYTES;
    localparam int               BEAT_W    = 8 * BEAT_BYTES;
    localparam logic [1:0]       LANE_MASK = 2'(BEAT_BYTES - 1);
    localparam logic [ADDR_W-1:0] BEAT_MASK = ADDR_W'(BEAT_BYTES - 1);

    generate
        if (!beat_bytes_legal(BEAT_BYTES)) begin : g_bad_beat_bytes
            $error("load_store_sequencer: BEAT_BYTES must be 1, 2 or 4");
        end
    endgenerate

    lsu_state_e        state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              we_q;
    logic [2:0]        funct3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              err_q;
    logic              cap_valid_q;
    logic [1:0]        cap_idx_q;
    logic [31:0]       rbuf_q;

    logic [1:0]        req_lg;
    logic [1:0]        req_smask;
    logic              req_trap;
    logic [ADDR_W-1:0] req_eff_addr;
    logic [31:0]       req_wmask;

    // Request decode: the effective address always has its low bits cleared to
    // size alignment, so in non-trap builds a misaligned access simply proceeds.
    always_comb begin
        req_lg       = size_log2(bus.req_funct3[1:0]);
        req_smask    = (req_lg == 2'd0) ? 2'b00 : (req_lg == 2'd1) ? 2'b01 : 2'b11;
        req_eff_addr = {bus.req_addr[ADDR_W-1:2], bus.req_addr[1:0] & ~req_smask};
        req_wmask    = (req_lg == 2'd0) ? 32'h0000_00ff :
                       (req_lg == 2'd1) ? 32'h0000_ffff : 32'hffff_ffff;
`ifdef LSU_MISALIGN_TRAP_EN
        req_trap     = !funct3_legal(bus.req_we, bus.req_funct3) ||
                       ((bus.req_addr[1:0] & req_smask) != 2'b00);
`else
        req_trap     = !funct3_legal(bus.req_we, bus.req_funct3);
`endif
    end

    logic [1:0]        lg_q;
    logic [1:0]        last_idx;
    logic [1:0]        lane_off;
    logic [3:0]        be4;
    logic [ADDR_W-1:0] beat_base;
    logic [31:0]       wshift;
    logic [BEAT_W-1:0] din_sel;

    // Beat geometry: sub-beat accesses use one beat and a lane offset; wider
    // accesses are beat-aligned and take S/BEAT_BYTES beats.
    always_comb begin
        lg_q = funct3_q[1:0];
        if (LG_BB == 0) begin
            last_idx = (lg_q == 2'd0) ? 2'd0 : (lg_q == 2'd1) ? 2'd1 : 2'd3;
        end else if (LG_BB == 1) begin
            last_idx = (lg_q == 2'd2) ? 2'd1 : 2'd0;
        end else begin
            last_idx = 2'd0;
        end
        lane_off  = addr_q[1:0] & LANE_MASK;
        be4       = ((lg_q == 2'd0) ? 4'b0001 : (lg_q == 2'd1) ? 4'b0011 : 4'b1111) << lane_off;
        beat_base = addr_q & ~BEAT_MASK;
        wshift    = wdata_q << {lane_off, 3'b000};
        din_sel   = '0;
        for (int b = 0; b < MAX_BEATS; b++) begin
            if (cnt_q == 2'(b)) din_sel = wshift[b*BEAT_W +: BEAT_W];
        end
    end

    logic ready_c, issue_c, rsp_c;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_c = 1'b0;
        issue_c = 1'b0;
        rsp_c   = 1'b0;
        case (state_q)
            S_IDLE: begin
                ready_c = 1'b1;
                cnt_d   = 2'd0;
                if (bus.req_valid) state_d = req_trap ? S_RESP : S_ISSUE;
            end
            S_ISSUE: begin
                issue_c = 1'b1;
                if (cnt_q == last_idx) begin
                    cnt_d   = 2'd0;
                    state_d = we_q ? S_RESP : S_DRAIN;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            S_DRAIN: state_d = S_RESP;
            S_RESP: begin
                rsp_c   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sysclk or negedge sysreset) begin
        if (!sysreset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 2'd0;
            we_q        <= 1'b0;
            funct3_q    <= 3'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            err_q       <= 1'b0;
            cap_valid_q <= 1'b0;
            cap_idx_q   <= 2'd0;
            rbuf_q      <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == S_IDLE && bus.req_valid) begin
                we_q     <= bus.req_we;
                funct3_q <= bus.req_funct3;
                addr_q   <= req_eff_addr;
                wdata_q  <= bus.req_wdata & req_wmask;
                err_q    <= req_trap;
            end
            // Read data trails its beat by one cycle; the last one lands in DRAIN.
            cap_valid_q <= issue_c && !we_q;
            cap_idx_q   <= cnt_q;
            if (cap_valid_q) begin
                for (int b = 0; b < MAX_BEATS; b++) begin
                    if (cap_idx_q == 2'(b)) rbuf_q[b*BEAT_W +: BEAT_W] <= bus.dmem_dout;
                end
            end
        end
    end

    logic [31:0] load_data;

    lsu_load_extend u_load_extend (
        .data     (rbuf_q),
        .lane_off (lane_off),
        .funct3   (funct3_q),
        .rdata    (load_data)
    );

    assign fsm_state     = state_q;
    assign bus.req_ready = ready_c;
    assign bus.rsp_valid = rsp_c;
    assign bus.rsp_err   = rsp_c && err_q;
    assign bus.rsp_rdata = (rsp_c && !we_q && !err_q) ? load_data : 32'b0;
    assign bus.dmem_en   = issue_c;
    assign bus.dmem_we   = issue_c && we_q;
    assign bus.dmem_addr = issue_c ? (beat_base + (ADDR_W'(cnt_q) << LG_BB)) : '0;
    assign bus.dmem_be   = issue_c ? be4[BEAT_BYTES-1:0] : '0;
    assign bus.dmem_din  = issue_c ? din_sel : '0;

endmodule

// File: tb/tb_load_store_sequencer.sv
// Directed bench for load_store_sequencer: three instances (BEAT_BYTES 1, 2, 4)
// share one byte-addressed memory model; one task per scenario.
module tb_load_store_sequencer;
    import lsu_pkg::*;

    logic sysclk   = 1'b0;
    logic sysreset = 1'b0;
    always #5 sysclk = ~sysclk;

    load_store_sequencer_if #(.ADDR_W(32), .BEAT_BYTES(1)) bus1 ();
    load_store_sequencer_if #(.ADDR_W(32), .BEAT_BYTES(2)) bus2 ();
    load_store_sequencer_if #(.ADDR_W(32), .BEAT_BYTES(4)) bus4 ();
    lsu_state_e st1, st2, st4;

    load_store_sequencer #(.BEAT_BYTES(1), .ADDR_W(32)) u_b1 (
        .sysclk(sysclk), .sysreset(sysreset), .bus(bus1), .fsm_state(st1));
    load_store_sequencer #(.BEAT_BYTES(2), .ADDR_W(32)) u_b2 (
        .sysclk(sysclk), .sysreset(sysreset), .bus(bus2), .fsm_state(st2));
    load_store_sequencer #(.BEAT_BYTES(4), .ADDR_W(32)) u_b4 (
        .sysclk(sysclk), .sysreset(sysreset), .bus(bus4), .fsm_state(st4));

    int          sel = 1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b0;
    logic [31:0] req_addr = 32'b0;
    logic [31:0] req_wdata = 32'b0;

    assign bus1.req_valid = req_valid && (sel == 1);
    assign bus2.req_valid = req_valid && (sel == 2);
    assign bus4.req_valid = req_valid && (sel == 4);
    assign bus1.req_we = req_we;         assign bus2.req_we = req_we;         assign bus4.req_we = req_we;
    assign bus1.req_funct3 = req_funct3; assign bus2.req_funct3 = req_funct3; assign bus4.req_funct3 = req_funct3;
    assign bus1.req_addr = req_addr;     assign bus2.req_addr = req_addr;     assign bus4.req_addr = req_addr;
    assign bus1.req_wdata = req_wdata;   assign bus2.req_wdata = req_wdata;   assign bus4.req_wdata = req_wdata;

    logic [7:0] mem [0:1023];
    logic       pl_en = 1'b0;
    logic [9:0] pl_addr = 10'b0;
    logic [7:0] pl_data = 8'b0;

    always @(posedge sysclk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        if (bus1.dmem_en) begin
            if (bus1.dmem_we) begin
                if (bus1.dmem_be[0]) mem[bus1.dmem_addr[9:0]] <= bus1.dmem_din;
            end else begin
                bus1.dmem_dout <= mem[bus1.dmem_addr[9:0]];
            end
        end
        if (bus2.dmem_en) begin
            if (bus2.dmem_we) begin
                for (int i = 0; i < 2; i++)
                    if (bus2.dmem_be[i]) mem[bus2.dmem_addr[9:0] + 10'(i)] <= bus2.dmem_din[i*8 +: 8];
            end else begin
                bus2.dmem_dout <= {mem[bus2.dmem_addr[9:0] + 10'd1], mem[bus2.dmem_addr[9:0]]};
            end
        end
        if (bus4.dmem_en) begin
            if (bus4.dmem_we) begin
                for (int i = 0; i < 4; i++)
                    if (bus4.dmem_be[i]) mem[bus4.dmem_addr[9:0] + 10'(i)] <= bus4.dmem_din[i*8 +: 8];
            end else begin
                bus4.dmem_dout <= {mem[bus4.dmem_addr[9:0] + 10'd3], mem[bus4.dmem_addr[9:0] + 10'd2],
                                   mem[bus4.dmem_addr[9:0] + 10'd1], mem[bus4.dmem_addr[9:0]]};
            end
        end
    end

    logic        obs_ready, obs_rsp, obs_err, obs_en, obs_we;
    logic [31:0] obs_rdata, obs_addr, obs_din;
    logic [3:0]  obs_be;
    lsu_state_e  obs_state;

    always_comb begin
        obs_ready = 1'b0; obs_rsp = 1'b0; obs_err = 1'b0; obs_en = 1'b0; obs_we = 1'b0;
        obs_rdata = '0; obs_addr = '0; obs_din = '0; obs_be = '0; obs_state = S_IDLE;
        case (sel)
            1: begin
                obs_ready = bus1.req_ready; obs_rsp = bus1.rsp_valid; obs_err = bus1.rsp_err;
                obs_rdata = bus1.rsp_rdata; obs_en = bus1.dmem_en; obs_we = bus1.dmem_we;
                obs_addr = bus1.dmem_addr; obs_be = {3'b0, bus1.dmem_be};
                obs_din = {24'b0, bus1.dmem_din}; obs_state = st1;
            end
            2: begin
                obs_ready = bus2.req_ready; obs_rsp = bus2.rsp_valid; obs_err = bus2.rsp_err;
                obs_rdata = bus2.rsp_rdata; obs_en = bus2.dmem_en; obs_we = bus2.dmem_we;
                obs_addr = bus2.dmem_addr; obs_be = {2'b0, bus2.dmem_be};
                obs_din = {16'b0, bus2.dmem_din}; obs_state = st2;
            end
            default: begin
                obs_ready = bus4.req_ready; obs_rsp = bus4.rsp_valid; obs_err = bus4.rsp_err;
                obs_rdata = bus4.rsp_rdata; obs_en = bus4.dmem_en; obs_we = bus4.dmem_we;
                obs_addr = bus4.dmem_addr; obs_be = bus4.dmem_be;
                obs_din = bus4.dmem_din; obs_state = st4;
            end
        endcase
    end

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp;

    task automatic step();
        @(posedge sysclk);
        #1;
    endtask

    task automatic preload(input logic [9:0] a, input logic [7:0] d);
        pl_addr = a; pl_data = d; pl_en = 1'b1;
        step();
        pl_en = 1'b0;
    endtask

    // Returns one time unit after the accept edge, i.e. in cycle 1 of the access.
    task automatic send(input int s, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata);
        int waited;
        sel = s; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        #1;
        waited = 0;
        while (obs_ready !== 1'b1 && waited < 20) begin
            step();
            waited++;
        end
        if (waited == 20) begin
            n_checks++;
            $display("FAIL send_ready: got req_ready %b expected 1 within 20 cycles", obs_ready);
        end
        step();
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        int sels[3] = '{1, 2, 4};
        repeat (2) step();
        foreach (sels[i]) begin
            sel = sels[i];
            #1;
            n_checks++; if (obs_ready !== 1'b1) $display("FAIL rst_ready b%0d: got %b expected 1", sel, obs_ready); else n_pass++;
            n_checks++; if (obs_rsp !== 1'b0) $display("FAIL rst_rsp b%0d: got %b expected 0", sel, obs_rsp); else n_pass++;
            n_checks++; if (obs_en !== 1'b0) $display("FAIL rst_en b%0d: got %b expected 0", sel, obs_en); else n_pass++;
            n_checks++; if (obs_state !== S_IDLE) $display("FAIL rst_state b%0d: got %0d expected 0", sel, obs_state); else n_pass++;
        end
        sysreset = 1'b1;
        step();
    endtask

    task automatic test_lw_beats1();
        preload(10'h100, 8'h11); preload(10'h101, 8'h22);
        preload(10'h102, 8'h33); preload(10'h103, 8'h44);
        exp_q.push_back(32'h4433_2211);
        send(1, 1'b0, F3_W, 32'h100, 32'h0);
        for (int c = 1; c <= 6; c++) begin
            if (c <= 4) begin
                n_checks++; if (obs_en !== 1'b1) $display("FAIL lw1_en c%0d: got %b expected 1", c, obs_en); else n_pass++;
                n_checks++; if (obs_addr !== 32'h100 + 32'(c - 1)) $display("FAIL lw1_addr c%0d: got %h expected %h", c, obs_addr, 32'h100 + 32'(c - 1)); else n_pass++;
                n_checks++; if (obs_be !== 4'b0001 || obs_we !== 1'b0) $display("FAIL lw1_be_we c%0d: got be %b we %b expected 0001 0", c, obs_be, obs_we); else n_pass++;
            end else if (c == 5) begin
                n_checks++; if (obs_en !== 1'b0 || obs_rsp !== 1'b0) $display("FAIL lw1_drain: got en %b rsp %b expected 0 0", obs_en, obs_rsp); else n_pass++;
            end else begin
                exp = exp_q.pop_front();
                n_checks++; if (obs_rsp !== 1'b1) $display("FAIL lw1_rsp_valid: got %b expected 1", obs_rsp); else n_pass++;
                n_checks++; if (obs_rdata !== exp) $display("FAIL lw1_rdata: got %h expected %h", obs_rdata, exp); else n_pass++;
                n_checks++; if (obs_err !== 1'b0) $display("FAIL lw1_err: got %b expected 0", obs_err); else n_pass++;
            end
            if (c < 6) step();
        end
        step();
        n_checks++; if (obs_rsp !== 1'b0 || obs_ready !== 1'b1) $display("FAIL lw1_after: got rsp %b ready %b expected 0 1", obs_rsp, obs_ready); else n_pass++;
    endtask

    task automatic test_sub_beat_loads();
        logic [2:0]  f3_t[4]  = '{F3_B, F3_BU, F3_H, F3_HU};
        logic [31:0] adr_t[4] = '{32'h203, 32'h203, 32'h202, 32'h202};
        logic [3:0]  be_t[4]  = '{4'b1000, 4'b1000, 4'b1100, 4'b1100};
        logic [31:0] exp_t[4] = '{32'hffff_ff80, 32'h0000_0080, 32'hffff_8034, 32'h0000_8034};
        preload(10'h202, 8'h34); preload(10'h203, 8'h80);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(exp_t[i]);
            send(4, 1'b0, f3_t[i], adr_t[i], 32'h0);
            n_checks++; if (obs_en !== 1'b1 || obs_addr !== 32'h200) $display("FAIL sub_beat%0d: got en %b addr %h expected 1 00000200", i, obs_en, obs_addr); else n_pass++;
            n_checks++; if (obs_be !== be_t[i]) $display("FAIL sub_be%0d: got %b expected %b", i, obs_be, be_t[i]); else n_pass++;
            step();
            n_checks++; if (obs_en !== 1'b0 || obs_rsp !== 1'b0) $display("FAIL sub_drain%0d: got en %b rsp %b expected 0 0", i, obs_en, obs_rsp); else n_pass++;
            step();
            exp = exp_q.pop_front();
            n_checks++; if (obs_rsp !== 1'b1 || obs_rdata !== exp) $display("FAIL sub_rdata%0d: got rsp %b data %h expected 1 %h", i, obs_rsp, obs_rdata, exp); else n_pass++;
            step();
        end
    endtask

    task automatic test_stores();
        send(2, 1'b1, F3_W, 32'h40, 32'hdead_beef);
        n_checks++; if (obs_en !== 1'b1 || obs_we !== 1'b1 || obs_addr !== 32'h40) $display("FAIL sw2_beat0: got en %b we %b addr %h expected 1 1 00000040", obs_en, obs_we, obs_addr); else n_pass++;
        n_checks++; if (obs_din !== 32'h0000_beef || obs_be !== 4'b0011) $display("FAIL sw2_din0: got din %h be %b expected 0000beef 0011", obs_din, obs_be); else n_pass++;
        step();
        n_checks++; if (obs_en !== 1'b1 || obs_addr !== 32'h42) $display("FAIL sw2_beat1: got en %b addr %h expected 1 00000042", obs_en, obs_addr); else n_pass++;
        n_checks++; if (obs_din !== 32'h0000_dead || obs_be !== 4'b0011) $display("FAIL sw2_din1: got din %h be %b expected 0000dead 0011", obs_din, obs_be); else n_pass++;
        step();
        n_checks++; if (obs_rsp !== 1'b1 || obs_err !== 1'b0 || obs_rdata !== 32'h0) $display("FAIL sw2_rsp: got rsp %b err %b data %h expected 1 0 00000000", obs_rsp, obs_err, obs_rdata); else n_pass++;
        step();
        exp_q.push_back(32'hdead_beef);
        send(2, 1'b0, F3_W, 32'h40, 32'h0);
        step(); step();
        n_checks++; if (obs_rsp !== 1'b0) $display("FAIL lw2_early: got rsp %b expected 0", obs_rsp); else n_pass++;
        step();
        exp = exp_q.pop_front();
        n_checks++; if (obs_rsp !== 1'b1 || obs_rdata !== exp) $display("FAIL lw2_readback: got rsp %b data %h expected 1 %h", obs_rsp, obs_rdata, exp); else n_pass++;
        step();
        send(4, 1'b1, F3_B, 32'h201, 32'h0000_00a5);
        n_checks++; if (obs_din !== 32'h0000_a500 || obs_be !== 4'b0010 || obs_addr !== 32'h200) $display("FAIL sb4_beat: got din %h be %b addr %h expected 0000a500 0010 00000200", obs_din, obs_be, obs_addr); else n_pass++;
        step();
        n_checks++; if (obs_rsp !== 1'b1 || obs_en !== 1'b0) $display("FAIL sb4_rsp: got rsp %b en %b expected 1 0", obs_rsp, obs_en); else n_pass++;
        step();
        exp_q.push_back(32'h0000_00a5);
        send(4, 1'b0, F3_BU, 32'h201, 32'h0);
        step(); step();
        exp = exp_q.pop_front();
        n_checks++; if (obs_rsp !== 1'b1 || obs_rdata !== exp) $display("FAIL sb4_readback: got rsp %b data %h expected 1 %h", obs_rsp, obs_rdata, exp); else n_pass++;
        step();
    endtask

    task automatic test_misalign();
        send(1, 1'b0, F3_H, 32'h101, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        n_checks++; if (obs_rsp !== 1'b1 || obs_err !== 1'b1) $display("FAIL mis_trap: got rsp %b err %b expected 1 1", obs_rsp, obs_err); else n_pass++;
        n_checks++; if (obs_en !== 1'b0) $display("FAIL mis_no_beat: got en %b expected 0", obs_en); else n_pass++;
        step();
`else
        n_checks++; if (obs_en !== 1'b1 || obs_addr !== 32'h100) $display("FAIL mis_beat0: got en %b addr %h expected 1 00000100", obs_en, obs_addr); else n_pass++;
        step();
        n_checks++; if (obs_en !== 1'b1 || obs_addr !== 32'h101) $display("FAIL mis_beat1: got en %b addr %h expected 1 00000101", obs_en, obs_addr); else n_pass++;
        step(); step();
        n_checks++; if (obs_rsp !== 1'b1 || obs_err !== 1'b0 || obs_rdata !== 32'h0000_2211) $display("FAIL mis_rsp: got rsp %b err %b data %h expected 1 0 00002211", obs_rsp, obs_err, obs_rdata); else n_pass++;
        step();
`endif
        n_checks++; if (obs_ready !== 1'b1) $display("FAIL mis_ready: got %b expected 1", obs_ready); else n_pass++;
    endtask

    task automatic test_illegal();
        int          s_t[2]  = '{4, 2};
        logic        we_t[2] = '{1'b0, 1'b1};
        logic [2:0]  f3_t[2] = '{3'b011, 3'b100};
        for (int i = 0; i < 2; i++) begin
            send(s_t[i], we_t[i], f3_t[i], 32'h100, 32'h0);
            n_checks++; if (obs_rsp !== 1'b1 || obs_err !== 1'b1) $display("FAIL ill_rsp%0d: got rsp %b err %b expected 1 1", i, obs_rsp, obs_err); else n_pass++;
            n_checks++; if (obs_en !== 1'b0 || obs_rdata !== 32'h0) $display("FAIL ill_quiet%0d: got en %b data %h expected 0 00000000", i, obs_en, obs_rdata); else n_pass++;
            step();
            n_checks++; if (obs_rsp !== 1'b0 || obs_ready !== 1'b1) $display("FAIL ill_after%0d: got rsp %b ready %b expected 0 1", i, obs_rsp, obs_ready); else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        logic seen;
        send(1, 1'b0, F3_W, 32'h100, 32'h0);
        step();
        n_checks++; if (obs_en !== 1'b1 || obs_addr !== 32'h101) $display("FAIL rm_beat2: got en %b addr %h expected 1 00000101", obs_en, obs_addr); else n_pass++;
        #1 sysreset = 1'b0;
        #1;
        n_checks++; if (obs_en !== 1'b0 || obs_addr !== 32'h0) $display("FAIL rm_en_drop: got en %b addr %h expected 0 00000000", obs_en, obs_addr); else n_pass++;
        n_checks++; if (obs_ready !== 1'b1 || obs_state !== S_IDLE) $display("FAIL rm_idle: got ready %b state %0d expected 1 0", obs_ready, obs_state); else n_pass++;
        seen = obs_rsp;
        repeat (2) begin step(); if (obs_rsp !== 1'b0) seen = 1'b1; end
        sysreset = 1'b1;
        repeat (6) begin step(); if (obs_rsp !== 1'b0) seen = 1'b1; end
        n_checks++; if (seen !== 1'b0) $display("FAIL rm_no_rsp: got rsp seen %b expected 0", seen); else n_pass++;
        exp_q.push_back(32'h4433_2211);
        send(1, 1'b0, F3_W, 32'h100, 32'h0);
        n_checks++; if (obs_en !== 1'b1 || obs_addr !== 32'h100) $display("FAIL rm_restart: got en %b addr %h expected 1 00000100", obs_en, obs_addr); else n_pass++;
        repeat (5) step();
        exp = exp_q.pop_front();
        n_checks++; if (obs_rsp !== 1'b1 || obs_rdata !== exp) $display("FAIL rm_rdata: got rsp %b data %h expected 1 %h", obs_rsp, obs_rdata, exp); else n_pass++;
        step();
    endtask

    task automatic test_back_to_back();
        exp_q.push_back(32'h4433_2211);
        exp_q.push_back(32'h0000_4433);
        send(4, 1'b0, F3_W, 32'h100, 32'h0);
        n_checks++; if (obs_ready !== 1'b0 || obs_be !== 4'b1111) $display("FAIL b2b_busy: got ready %b be %b expected 0 1111", obs_ready, obs_be); else n_pass++;
        step(); step();
        exp = exp_q.pop_front();
        n_checks++; if (obs_rsp !== 1'b1 || obs_rdata !== exp) $display("FAIL b2b_first: got rsp %b data %h expected 1 %h", obs_rsp, obs_rdata, exp); else n_pass++;
        send(4, 1'b0, F3_HU, 32'h102, 32'h0);
        n_checks++; if (obs_en !== 1'b1 || obs_addr !== 32'h100 || obs_be !== 4'b1100) $display("FAIL b2b_beat: got en %b addr %h be %b expected 1 00000100 1100", obs_en, obs_addr, obs_be); else n_pass++;
        step(); step();
        exp = exp_q.pop_front();
        n_checks++; if (obs_rsp !== 1'b1 || obs_rdata !== exp) $display("FAIL b2b_second: got rsp %b data %h expected 1 %h", obs_rsp, obs_rdata, exp); else n_pass++;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_lw_beats1();
        test_sub_beat_loads();
        test_stores();
        test_misalign();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
